rr_priority_encoder: RTL and testbench

- Registered, parametrised successor to the combinational priority encoder.
- Picks one of N request lines and presents its index and one-hot form on a valid/ready output channel.
- Supports fixed-priority mode (highest index wins) and round-robin mode, selectable at run time.
- Sits between request sources (IRQ lines, channel requesters) and a single consumer that acknowledges each grant.

---
 rtl/rr_priority_encoder.sv | 114 +++++++++++
 tb/tb_rr_priority_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
// Registered N-way request arbiter with a valid/ready grant channel.
// Fixed-priority mode always favours the highest set index; round-robin
// mode rotates priority so an accepted requester becomes lowest priority.
module rr_priority_encoder #(
  parameter int N = 8,
  parameter int M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode_rr,
  output logic         out_valid,
  output logic [M-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  input  logic         out_ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Pointer value meaning "highest index has top priority".
  localparam logic [M-1:0] PTR_TOP = M'(N - 1);
  localparam logic [N-1:0] ONE_BIT = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [M-1:0] ptr, ptr_nxt;
  logic [M-1:0] rr_after;
  logic         handshake;
  logic         win_found;
  logic [M-1:0] win_idx;
  logic         valid_nxt;
  logic [M-1:0] idx_nxt;
  logic [N-1:0] onehot_nxt;

  // Pointer update: forced to the top in fixed mode, rotated past the
  // accepted grant in round-robin mode, otherwise held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; an unassigned path would infer a latch.
    handshake = (state == GRANT) && out_ready;
    rr_after  = (out_idx == '0) ? PTR_TOP : out_idx - M'(1);
    ptr_nxt   = ptr;
    if (!mode_rr) begin
      ptr_nxt = PTR_TOP;
    end else if (handshake) begin
      ptr_nxt = rr_after;
    end
  end

  // Winner search: the set request closest below the updated pointer,
  // wrapping from 0 to N-1, wins. Using ptr_nxt lets a handshake
  // re-arbitrate in the same cycle with the rotated priority.
  always_comb begin : search
    int p;
    int d;
    int best_d;
    win_found = 1'b0;
    win_idx   = '0;
    best_d    = N;
    p         = int'(ptr_nxt);
    for (int j = 0; j < N; j++) begin
      d = (p >= j) ? (p - j) : (p + N - j);
      if (req[j] && (d < best_d)) begin
        best_d    = d;
        win_idx   = M'(j);
        win_found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic: a grant is only replaced when idle
  // or when the consumer accepts it; otherwise everything holds.
  always_comb begin
    state_nxt  = state;
    valid_nxt  = out_valid;
    idx_nxt    = out_idx;
    onehot_nxt = out_onehot;
    if ((state == IDLE) || handshake) begin
      if (win_found) begin
        state_nxt  = GRANT;
        valid_nxt  = 1'b1;
        idx_nxt    = win_idx;
        onehot_nxt = ONE_BIT << win_idx;
      end else begin
        state_nxt  = IDLE;
        valid_nxt  = 1'b0;
        onehot_nxt = '0;
      end
    end
  end

  // State, pointer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= PTR_TOP;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      out_valid  <= valid_nxt;
      out_idx    <= idx_nxt;
      out_onehot <= onehot_nxt;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// tb_rr_priority_encoder
// Directed bench for an N=8 and an N=5 instance. A per-instance behavioural
// model (modular-arithmetic search order) is compared on every falling edge;
// literal expectations along the stimulus pin the model itself.
module tb_rr_priority_encoder;

  typedef struct {
    bit valid;
    int idx;
    int ptr;
  } mstate_t;

  logic       clk;
  logic       rst_n;
  logic       mode_rr;
  logic       out_ready;
  logic [7:0] req8;
  logic [4:0] req5;
  logic       valid8, valid5;
  logic [2:0] idx8, idx5;
  logic [7:0] onehot8;
  logic [4:0] onehot5;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  mstate_t m8 = '{valid: 1'b0, idx: 0, ptr: 7};
  mstate_t m5 = '{valid: 1'b0, idx: 0, ptr: 4};

  rr_priority_encoder #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req8),
    .mode_rr   (mode_rr),
    .out_valid (valid8),
    .out_idx   (idx8),
    .out_onehot(onehot8),
    .out_ready (out_ready)
  );

  rr_priority_encoder #(.N(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req5),
    .mode_rr   (mode_rr),
    .out_valid (valid5),
    .out_idx   (idx5),
    .out_onehot(onehot5),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour: search order p, p-1, ... wrapping modulo n.
  function automatic mstate_t step(input mstate_t s, input int n, input logic [7:0] r,
                                   input bit mode, input bit ready, input bit rst);
    mstate_t q = s;
    bit hs;
    int p;
    if (!rst) begin
      q.valid = 1'b0;
      q.idx   = 0;
      q.ptr   = n - 1;
      return q;
    end
    hs = s.valid && ready;
    if (!mode)   q.ptr = n - 1;
    else if (hs) q.ptr = (s.idx == 0) ? n - 1 : s.idx - 1;
    if (!s.valid || hs) begin
      q.valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        p = ((q.ptr - i) % n + n) % n;
        if (r[p[2:0]]) begin
          q.valid = 1'b1;
          q.idx   = p;
          break;
        end
      end
    end
    return q;
  endfunction

  // Model advances on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    m8 <= step(m8, 8, req8, mode_rr, out_ready, rst_n);
    m5 <= step(m5, 5, {3'b000, req5}, mode_rr, out_ready, rst_n);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m8_valid",  int'(valid8),  int'(m8.valid));
      check("m8_idx",    int'(idx8),    m8.idx);
      check("m8_onehot", int'(onehot8), m8.valid ? (1 << m8.idx) : 0);
      check("m5_valid",  int'(valid5),  int'(m5.valid));
      check("m5_idx",    int'(idx5),    m5.idx);
      check("m5_onehot", int'(onehot5), m5.valid ? (1 << m5.idx) : 0);
      check("m5_idx_lt_n", int'(idx5 < 3'd5), 1);
    end
  end

  // Apply one cycle of inputs at the falling edge; return at the next one.
  task automatic drive(input logic [7:0] r8, input logic [4:0] r5,
                       input bit m, input bit rdy);
    req8      = r8;
    req5      = r5;
    mode_rr   = m;
    out_ready = rdy;
    @(negedge clk);
  endtask

  int exp_rr[4] = '{5, 2, 1, 7};

  initial begin
    rst_n     = 1'b0;
    req8      = '0;
    req5      = '0;
    mode_rr   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_valid",  int'(valid8),  0);
    check("rst_idx",    int'(idx8),    0);
    check("rst_onehot", int'(onehot8), 0);
    rst_n = 1'b1;

    // Fixed mode walk: single request i granted one cycle later.
    for (int i = 0; i < 8; i++) begin
      drive(8'(1 << i), 5'd0, 1'b0, 1'b1);
      check("walk_valid",  int'(valid8),  1);
      check("walk_idx",    int'(idx8),    i);
      check("walk_onehot", int'(onehot8), 1 << i);
    end
    drive(8'h00, 5'd0, 1'b0, 1'b1);
    check("walk_idle_valid",  int'(valid8),  0);
    check("walk_idle_idx",    int'(idx8),    7);
    check("walk_idle_onehot", int'(onehot8), 0);

    // Fixed mode with several requests: highest always wins.
    for (int i = 0; i < 3; i++) begin
      drive(8'hA6, 5'd0, 1'b0, 1'b1);
      check("fixed_idx", int'(idx8), 7);
    end
    // Round-robin from the presented 7: 5, 2, 1, 7, no bubbles.
    for (int i = 0; i < 4; i++) begin
      drive(8'hA6, 5'd0, 1'b1, 1'b1);
      check("rr_idx",   int'(idx8),   exp_rr[i]);
      check("rr_valid", int'(valid8), 1);
    end
    drive(8'h00, 5'd0, 1'b1, 1'b1);
    check("rr_idle_valid", int'(valid8), 0);

    // Backpressure: grant 4 held while the request changes underneath it.
    drive(8'h11, 5'd0, 1'b1, 1'b0);
    check("bp_idx", int'(idx8), 4);
    for (int i = 0; i < 3; i++) begin
      drive(8'h01, 5'd0, 1'b1, 1'b0);
      check("bp_hold_idx",   int'(idx8),   4);
      check("bp_hold_valid", int'(valid8), 1);
    end
    drive(8'h01, 5'd0, 1'b1, 1'b1);
    check("bp_next_idx", int'(idx8), 0);
    drive(8'h00, 5'd0, 1'b1, 1'b1);

    // N=5 round-robin: alternates 4, 0 with wrap at 4.
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, 5'b10001, 1'b1, 1'b1);
      check("n5_idx", int'(idx5), (i % 2 == 0) ? 4 : 0);
    end
    drive(8'h00, 5'b00000, 1'b1, 1'b1);
    check("n5_idle_valid", int'(valid5), 0);

    // Reset while presenting grant 3.
    drive(8'h08, 5'd0, 1'b1, 1'b0);
    check("pre_rst_idx", int'(idx8), 3);
    rst_n = 1'b0;
    drive(8'hFF, 5'd0, 1'b1, 1'b0);
    check("mid_rst_valid",  int'(valid8),  0);
    check("mid_rst_idx",    int'(idx8),    0);
    check("mid_rst_onehot", int'(onehot8), 0);
    rst_n = 1'b1;
    drive(8'hFF, 5'd0, 1'b1, 1'b1);
    check("post_rst_idx", int'(idx8), 7);
    drive(8'hFF, 5'd0, 1'b1, 1'b1);
    check("post_rst_next", int'(idx8), 6);

    // Back to fixed mode: pointer snaps to the top again.
    drive(8'hFF, 5'd0, 1'b0, 1'b1);
    check("fixed_again", int'(idx8), 7);
    drive(8'h03, 5'd0, 1'b0, 1'b1);
    check("fixed_low", int'(idx8), 1);
    drive(8'h00, 5'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
